// File: rtl/rx_package.sv
// Shared RX definitions: setting width, sweep timing defaults and sweep FSM state encoding.
package rx_package;

  localparam int unsigned RX_SETTING_WIDTH    = 4;
  localparam int unsigned SWEEP_SETTLE_CYCLES = 16;
  localparam int unsigned SWEEP_MEASURE_VALID = 1024;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SETTLE,
    MEASURE,
    NEXT,
    APPLY,
    FLUSH_FINAL
  } sweep_state_t;

endpackage

// File: rtl/sweep_err_counter.sv
// Valid-beat and bit-error counters for one measurement window.
//  clk, rst_n    clock, async active-low reset
//  clear         synchronous clear of both counters
//  en            window open; beats outside it are ignored
//  sample_valid  rx_bit/ref_bit qualify this cycle
//  rx_bit        sliced RX decision
//  ref_bit       reference bit, time-aligned to rx_bit
//  meas_done     combinational: this beat is the last one of the window
//  err_cnt       errors counted so far in the window
module sweep_err_counter #(
  parameter int unsigned MEASURE_VALID = 1024,
  parameter int unsigned ERR_WIDTH     = $clog2(MEASURE_VALID + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 sample_valid,
  input  logic                 rx_bit,
  input  logic                 ref_bit,
  output logic                 meas_done,
  output logic [ERR_WIDTH-1:0] err_cnt
);

  logic [ERR_WIDTH-1:0] valid_cnt_q;
  logic [ERR_WIDTH-1:0] err_cnt_q;
  logic                 beat;

  assign beat = en && sample_valid;

  // Combinational so the FSM leaves on the same edge that counts the last beat.
  assign meas_done = beat && (valid_cnt_q == ERR_WIDTH'(MEASURE_VALID - 1));
  assign err_cnt   = err_cnt_q;

  // Counter registers; err_cnt never exceeds MEASURE_VALID so no saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (clear) begin
      valid_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (beat) begin
      valid_cnt_q <= valid_cnt_q + ERR_WIDTH'(1);
      err_cnt_q   <= err_cnt_q + ERR_WIDTH'(rx_bit ^ ref_bit);
    end
  end

endmodule

// File: rtl/rx_setting_sweep.sv
// Sweeps every rx_setting code, flushing and settling the DFE before counting
// bit errors per code, then applies the code with the fewest errors.
//  clk, rst_n    clock, async active-low reset
//  start         single-cycle sweep request (ignored while busy)
//  sample_valid  rx_bit/ref_bit qualify this cycle
//  rx_bit        sliced RX decision
//  ref_bit       expected bit, time-aligned to rx_bit
//  rx_setting    code driven to rx_dfe
//  dfe_rst       active-high DFE history flush
//  busy          sweep in progress
//  done          one-cycle pulse when the best code has been applied
//  best_err      error count of the selected code
module rx_setting_sweep
  import rx_package::*;
#(
  parameter int unsigned SETTING_WIDTH = RX_SETTING_WIDTH,
  parameter int unsigned SETTLE_CYCLES = SWEEP_SETTLE_CYCLES,
  parameter int unsigned MEASURE_VALID = SWEEP_MEASURE_VALID,
  localparam int unsigned ERR_WIDTH    = $clog2(MEASURE_VALID + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sample_valid,
  input  logic                     rx_bit,
  input  logic                     ref_bit,
  output logic [SETTING_WIDTH-1:0] rx_setting,
  output logic                     dfe_rst,
  output logic                     busy,
  output logic                     done,
  output logic [ERR_WIDTH-1:0]     best_err
);

  localparam int unsigned N_SETTINGS = 2 ** SETTING_WIDTH;
  localparam int unsigned SETTLE_W   = $clog2(SETTLE_CYCLES + 1);

  sweep_state_t             state_q, state_d;
  logic [SETTING_WIDTH-1:0] setting_q, setting_d;
  logic [SETTING_WIDTH-1:0] best_code_q, best_code_d;
  logic [ERR_WIDTH-1:0]     best_err_q, best_err_d;
  logic [SETTLE_W-1:0]      settle_q, settle_d;
  logic                     dfe_rst_q, dfe_rst_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     cnt_clear;
  logic                     cnt_en;
  logic                     meas_done;
  logic [ERR_WIDTH-1:0]     err_cnt;

  sweep_err_counter #(
    .MEASURE_VALID (MEASURE_VALID),
    .ERR_WIDTH     (ERR_WIDTH)
  ) u_err_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (cnt_clear),
    .en           (cnt_en),
    .sample_valid (sample_valid),
    .rx_bit       (rx_bit),
    .ref_bit      (ref_bit),
    .meas_done    (meas_done),
    .err_cnt      (err_cnt)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    setting_d   = setting_q;
    best_code_d = best_code_q;
    best_err_d  = best_err_q;
    settle_d    = settle_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        if (start) begin
          setting_d   = '0;
          best_err_d  = '1;
          best_code_d = '0;
          state_d     = FLUSH;
        end
      end
      FLUSH: begin
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state_d = MEASURE;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      MEASURE: begin
        cnt_en = 1'b1;
        if (meas_done) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        cnt_clear = 1'b1;
        // Strict less-than: on a tie the earlier (lower) code is kept.
        if (err_cnt < best_err_q) begin
          best_err_d  = err_cnt;
          best_code_d = setting_q;
        end
        if (setting_q == SETTING_WIDTH'(N_SETTINGS - 1)) begin
          state_d = APPLY;
        end else begin
          setting_d = setting_q + SETTING_WIDTH'(1);
          state_d   = FLUSH;
        end
      end
      APPLY: begin
        setting_d = best_code_q;
        state_d   = FLUSH_FINAL;
      end
      FLUSH_FINAL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with the state register.
    dfe_rst_d = (state_d == FLUSH) || (state_d == FLUSH_FINAL);
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == FLUSH_FINAL);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      setting_q   <= '0;
      best_code_q <= '0;
      best_err_q  <= '1;
      settle_q    <= '0;
      dfe_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      setting_q   <= setting_d;
      best_code_q <= best_code_d;
      best_err_q  <= best_err_d;
      settle_q    <= settle_d;
      dfe_rst_q   <= dfe_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rx_setting = setting_q;
  assign best_err   = best_err_q;
  assign dfe_rst    = dfe_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_rx_setting_sweep.sv
// Directed bench for rx_setting_sweep with 4 codes, 4 settle cycles, 8 measured beats.
module tb_rx_setting_sweep;

  localparam int unsigned SW  = 2;
  localparam int unsigned EW  = 4;
  localparam int          ALL_ONES = 15;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sample_valid;
  logic          rx_bit;
  logic          ref_bit;
  logic [SW-1:0] rx_setting;
  logic          dfe_rst;
  logic          busy;
  logic          done;
  logic [EW-1:0] best_err;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int t0  = 0;
  int err_tab [4];
  bit toggle_mode = 1'b0;

  rx_setting_sweep #(
    .SETTING_WIDTH (SW),
    .SETTLE_CYCLES (4),
    .MEASURE_VALID (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sample_valid (sample_valid),
    .rx_bit       (rx_bit),
    .ref_bit      (ref_bit),
    .rx_setting   (rx_setting),
    .dfe_rst      (dfe_rst),
    .busy         (busy),
    .done         (done),
    .best_err     (best_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter; t0 marks the edge that accepted start, so period 0 is FLUSH of code 0.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (start && !busy && rst_n) t0 = cyc;
  end

  // Schedule-driven data: per code, FLUSH at offset 0, SETTLE 1..4, MEASURE from offset 5.
  always @(negedge clk) begin
    int pi, k, o;
    logic e;
    pi = cyc - t0;
    rx_bit = 1'($urandom_range(0, 1));
    if (toggle_mode) begin
      sample_valid = (pi >= 5) && (((pi - 5) % 2) == 1);
      ref_bit = sample_valid ? rx_bit : ~rx_bit;
    end else begin
      sample_valid = 1'b1;
      k = pi / 14;
      o = (pi % 14) - 5;
      e = 1'b0;
      if (pi >= 0 && k < 4) e = (o >= 0) && (o < err_tab[k]);
      ref_bit = rx_bit ^ e;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; start is sampled on the following posedge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // From period 0 of a sweep, wait for done; optionally pulse start at period pulse_at.
  task automatic wait_done(input int pulse_at, output int lat, output int pulses, output int hi);
    logic prev;
    lat = -1; pulses = 0; hi = 0; prev = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (dfe_rst) begin
        hi++;
        if (!prev) pulses++;
      end
      prev = dfe_rst;
      if (done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
      start = (n + 1 == pulse_at);
    end
    start = 1'b0;
    chk("done_seen", int'(lat >= 0), 1);
  endtask

  task automatic set_tab(input int a, input int b, input int c, input int d);
    err_tab[0] = a; err_tab[1] = b; err_tab[2] = c; err_tab[3] = d;
  endtask

  initial begin
    int lat, pulses, hi;
    rst_n = 1'b0; start = 1'b0;
    set_tab(0, 0, 0, 0);

    // 1: reset values, then idle after release
    repeat (2) @(negedge clk);
    chk("rst_dfe_rst", int'(dfe_rst), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_setting", int'(rx_setting), 0);
    chk("rst_best_err", int'(best_err), ALL_ONES);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_dfe_rst", int'(dfe_rst), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_setting", int'(rx_setting), 0);
    chk("idle_best_err", int'(best_err), ALL_ONES);
    repeat (3) @(negedge clk);

    // 2: clean data on every code
    do_start();
    chk("t2_busy_p0", int'(busy), 1);
    chk("t2_flush_p0", int'(dfe_rst), 1);
    wait_done(-1, lat, pulses, hi);
    chk("t2_latency", lat, 58);
    chk("t2_setting", int'(rx_setting), 0);
    chk("t2_best_err", int'(best_err), 0);
    chk("t2_busy_done", int'(busy), 0);
    @(negedge clk);
    chk("t2_done_width", int'(done), 0);
    repeat (2) @(negedge clk);

    // 3: injected errors {5,2,7,2}; tie between codes 1 and 3 keeps 1
    set_tab(5, 2, 7, 2);
    do_start();
    wait_done(-1, lat, pulses, hi);
    chk("t3_latency", lat, 58);
    chk("t3_setting", int'(rx_setting), 1);
    chk("t3_best_err", int'(best_err), 2);
    chk("t3_flush_pulses", pulses, 5);
    chk("t3_flush_cycles", hi, 5);

    // 4: start in the done cycle; sample_valid toggles, errors only on invalid beats
    toggle_mode = 1'b1;
    do_start();
    chk("t4_done_width", int'(done), 0);
    chk("t4_busy_p0", int'(busy), 1);
    wait_done(-1, lat, pulses, hi);
    chk("t4_latency", lat, 4 * 22 + 2);
    chk("t4_setting", int'(rx_setting), 0);
    chk("t4_best_err", int'(best_err), 0);
    toggle_mode = 1'b0;
    repeat (2) @(negedge clk);

    // 5: extra start mid-sweep is ignored
    set_tab(5, 2, 7, 2);
    do_start();
    wait_done(20, lat, pulses, hi);
    chk("t5_latency", lat, 58);
    chk("t5_setting", int'(rx_setting), 1);
    chk("t5_best_err", int'(best_err), 2);
    repeat (4) @(negedge clk);
    chk("t5_hold_setting", int'(rx_setting), 1);
    chk("t5_hold_best_err", int'(best_err), 2);

    // 6: reset during MEASURE of code 2, then a full sweep
    set_tab(3, 1, 4, 1);
    do_start();
    repeat (35) @(negedge clk);
    chk("t6_pre_setting", int'(rx_setting), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_setting", int'(rx_setting), 0);
    chk("t6_rst_dfe_rst", int'(dfe_rst), 1);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_done", int'(done), 0);
    chk("t6_rst_best_err", int'(best_err), ALL_ONES);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_done", int'(done), 0);
    end
    do_start();
    wait_done(-1, lat, pulses, hi);
    chk("t6_latency", lat, 58);
    chk("t6_setting", int'(rx_setting), 1);
    chk("t6_best_err", int'(best_err), 1);
    chk("t6_flush_pulses", pulses, 5);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
